// File: rtl/ripple_seq_adder_ctrl_pkg.sv
// Shared types and constants for the multi-word ripple add/subtract sequencer.
package ripple_seq_adder_ctrl_pkg;

    localparam int unsigned SLICE_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width of a counter able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        int unsigned p;
        w = 0;
        p = 1;
        while (p < n) begin
            p = p << 1;
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/ripple_seq_adder_ctrl_adder5.sv
// 5-bit ripple-carry adder: the single shared datapath slice of the sequencer.
module ripple_adder5
    import ripple_seq_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               carry_in,
    output logic               carry_out,
    output logic [SLICE_W-1:0] sum
);

    logic [SLICE_W:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry_out = c[SLICE_W];

endmodule

// File: rtl/ripple_seq_adder_ctrl.sv
// Sequences a WORDS x 5-bit add/subtract through one shared ripple_adder5,
// least significant slice first, chaining the carry through a register.
module ripple_seq_adder_ctrl
    import ripple_seq_adder_ctrl_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       sub,
    input  logic                       carry_in,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       carry_out,
    output logic                       overflow
);

    localparam int unsigned W     = SLICE_W * WORDS;
    localparam int unsigned IDX_W = clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign slice_a = a_q[idx_q * SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q * SLICE_W +: SLICE_W];

    ripple_adder5 u_adder (
        .a         (slice_a),
        .b         (slice_b),
        .carry_in  (carry_q),
        .carry_out (slice_cout),
        .sum       (slice_sum)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1, so the stored B is pre-inverted.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : carry_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q * SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[SLICE_W-1] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/ripple_seq_adder_ctrl.md
Name: ripple_seq_adder_ctrl

Overview:
- Multi-word add/subtract sequencer that reuses one 5-bit ripple adder to compute a WORDS×5-bit result, one 5-bit slice per clock, least significant slice first.
- Latches operands on a start request and steps a word counter through an FSM.
- Chains the carry between slices through a register, then presents the full-width result with carry-out and signed-overflow flags.
- Sits between a requesting unit and the shared ripple_adder5 datapath.

Parameters:
- WORDS, 4, number of 5-bit slices; total operand width W = 5*WORDS, range 2..16.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- sub  input  1  0 = a+b+carry_in; 1 = a-b (carry_in ignored).
- carry_in  input  1  initial carry for add.
- a  input  W  operand A, sampled on accept.
- b  input  W  operand B, sampled on accept.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  W  registered result.
- carry_out  output  1  carry out of the MSB slice; for sub, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, idx=0, carry_reg=0.
  - sum=0, carry_out=0, overflow=0, busy=0, done=0.
  - Operand registers cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse follows.
- IDLE: when start=1 at a rising edge:
  - Latch a into a_reg.
  - Latch b_eff into b_reg: b_eff = sub ? ~b : b.
  - carry_reg <= sub ? 1 : carry_in; idx <= 0; sum <= 0; state <= RUN.
- RUN, on each edge:
  - The shared adder sees a_reg[idx], b_reg[idx], carry_reg.
  - sum slice idx <= adder sum; carry_reg <= adder carry_out.
  - If idx==WORDS-1: carry_out <= adder carry_out, overflow <= (a_reg MSB == b_reg MSB) && (new sum MSB != a_reg MSB), state <= DONE.
  - Otherwise idx <= idx+1.
- DONE:
  - done=1 for exactly one cycle, then state <= IDLE.
  - start is ignored in DONE.
- Latency: start accepted at edge E0; slices are written at edges E1..E_WORDS; done is high in the cycle after E_WORDS (edge E_WORDS+1 returns to IDLE).
- busy is decoded combinationally from state.
- sum, carry_out and overflow hold their value from DONE until the next accepted start, which clears sum.
- start while busy=1 is ignored and has no side effects.
- Input changes after accept do not affect the operation in progress.
- Wrap-around: results are modulo 2^W; the carry/borrow is reported only through carry_out.
- Adder use: exactly one ripple_adder5 instance; its port order is (a, b, carry_in, carry_out, sum); no other adder in the block.

Decomposition:
- Shared package:
  - SLICE_W=5.
  - State enum IDLE/RUN/DONE (2-bit encoding 00/01/10).
  - Counter width function clog2(WORDS).
- Sub-module: the existing ripple_adder5, instantiated once, is the only sub-module.
- Slice selection/insertion is inline indexed part-select; no separate mux module.

Test Plan (WORDS=4, W=20, values in hex):
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; busy=0.
- Add: a=0000C, b=00013, carry_in=0, sub=0 -> sum=0001F, carry_out=0, overflow=0; done exactly 5 cycles after the accept edge, busy high for 5 cycles.
- Slice carry: a=0000C, b=00013, carry_in=1 -> sum=00020 (slice0 wraps, carry into slice1); full chain a=FFFFF, b=00001, carry_in=0 -> sum=00000, carry_out=1, overflow=0.
- Subtract: a=00005, b=00007, sub=1, carry_in=1 (ignored) -> sum=FFFFE, carry_out=0 (borrow), overflow=0; a=00007, b=00005, sub=1 -> sum=00002, carry_out=1.
- Signed overflow: a=7FFFF, b=00001, sub=0 -> sum=80000, overflow=1, carry_out=0.
- Control boundaries:
  - start held high through RUN and DONE -> only one operation; a new one is accepted in the first IDLE cycle.
  - rst pulsed at the 2nd RUN cycle -> IDLE, no done, outputs 0.
  - Next start a=00001, b=00001 -> sum=00002.
